// File: rtl/pp_rd_encoder_if.sv
// pp_rd_encoder_if: request, slave-response and response-FIFO signals of the read-path encoder.
// master = host/peripheral/FIFO environment side, slave = the encoder itself.
interface pp_rd_encoder_if #(
    parameter int TOTAL_GRP         = 4,
    parameter int ID_W              = $clog2(TOTAL_GRP),
    parameter int RD_DATA_BUS_WIDTH = 48,
    parameter int FIFO_W            = RD_DATA_BUS_WIDTH
);
    logic                         rd_req;
    logic [ID_W-1:0]              rd_slave_id;
    logic                         rd_dv;
    logic [RD_DATA_BUS_WIDTH-1:0] rd_data;
    logic                         fifo_full;
    logic                         busy;
    logic                         rd_req_ack;
    logic [TOTAL_GRP-1:0]         int_ack;
    logic                         fifo_en;
    logic [FIFO_W-1:0]            fifo_data;
    logic                         timeout_err;
    logic                         id_err;

    modport master (
        output rd_req, rd_slave_id, rd_dv, rd_data, fifo_full,
        input  busy, rd_req_ack, int_ack, fifo_en, fifo_data, timeout_err, id_err
    );

    modport slave (
        input  rd_req, rd_slave_id, rd_dv, rd_data, fifo_full,
        output busy, rd_req_ack, int_ack, fifo_en, fifo_data, timeout_err, id_err
    );
endinterface

// File: rtl/pp_rd_encoder.sv
// pp_rd_encoder: read-path encoder between the host read-request decoder and the response FIFO.
// Accepts a request for one peripheral group, acknowledges the group, waits (with timeout) for
// its data-valid and writes the captured word into the response FIFO under full backpressure.
// Optional build macro PP_RD_ENC_TAG_EN: prepends a TAG_W tag {timeout flag, 0.., group id}
// to every FIFO word and turns a timeout into a zero-data FIFO entry with the flag set.
module pp_rd_encoder #(
    parameter int TOTAL_GRP         = 4,
    parameter int ID_W              = $clog2(TOTAL_GRP),
    parameter int RD_DATA_BUS_WIDTH = 48,
    parameter int TIMEOUT_CYCLES    = 255,
    parameter int TAG_W             = 8
) (
    input logic            clk,
    input logic            rst_n,
    pp_rd_encoder_if.slave bus
);

`ifdef PP_RD_ENC_TAG_EN
    localparam int FIFO_W = RD_DATA_BUS_WIDTH + TAG_W;
`else
    localparam int FIFO_W = RD_DATA_BUS_WIDTH;
`endif

    // A zero timeout disables the abort; the timer still needs at least one bit.
    localparam bit              TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int              TMR_W    = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMO_EN ? TMR_W'(TIMEOUT_CYCLES - 1) : '1;

    if (TOTAL_GRP < 2 || TAG_W < ID_W + 1) begin : g_param_check
        $error("pp_rd_encoder: TOTAL_GRP must be >= 2 and TAG_W >= ID_W+1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DV, WRITE} state_t;

    state_t                       state_q, state_nxt;
    logic [ID_W-1:0]              id_q, id_nxt;
    logic [TMR_W-1:0]             tmr_q, tmr_nxt;
    logic [RD_DATA_BUS_WIDTH-1:0] data_q, data_nxt;
`ifdef PP_RD_ENC_TAG_EN
    logic                         to_flag_q, to_flag_nxt;
`endif

    logic                         rd_req_ack_q, rd_req_ack_nxt;
    logic [TOTAL_GRP-1:0]         int_ack_q, int_ack_nxt;
    logic                         fifo_en_q, fifo_en_nxt;
    logic [FIFO_W-1:0]            fifo_data_q, fifo_data_nxt;
    logic                         timeout_err_q, timeout_err_nxt;
    logic                         id_err_q, id_err_nxt;

    logic                         id_ok;

`ifdef PP_RD_ENC_TAG_EN
    // Tag layout: MSB = timeout flag, low ID_W bits = group id, everything else zero.
    function automatic logic [TAG_W-1:0] make_tag(input logic [ID_W-1:0] id, input logic flag);
        logic [TAG_W-1:0] t;
        t             = '0;
        t[ID_W-1:0]   = id;
        t[TAG_W-1]    = flag;
        return t;
    endfunction
`endif

    assign id_ok = (32'(bus.rd_slave_id) < 32'(TOTAL_GRP));

    // Next-state and next-output decode; every registered output defaults to a zero pulse.
    always_comb begin
        state_nxt       = state_q;
        id_nxt          = id_q;
        tmr_nxt         = tmr_q;
        data_nxt        = data_q;
`ifdef PP_RD_ENC_TAG_EN
        to_flag_nxt     = to_flag_q;
`endif
        rd_req_ack_nxt  = 1'b0;
        int_ack_nxt     = '0;
        fifo_en_nxt     = 1'b0;
        fifo_data_nxt   = '0;
        timeout_err_nxt = 1'b0;
        id_err_nxt      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.rd_req) begin
                    if (id_ok) begin
                        id_nxt    = bus.rd_slave_id;
                        state_nxt = ISSUE;
`ifdef PP_RD_ENC_TAG_EN
                        to_flag_nxt = 1'b0;
`endif
                    end else begin
                        id_err_nxt = 1'b1;
                    end
                end
            end

            ISSUE: begin
                int_ack_nxt = TOTAL_GRP'(1) << id_q;
                tmr_nxt     = '0;
                state_nxt   = WAIT_DV;
            end

            WAIT_DV: begin
                // Data arriving on the last timeout cycle takes priority over the abort.
                if (bus.rd_dv) begin
                    data_nxt       = bus.rd_data;
                    rd_req_ack_nxt = 1'b1;
                    state_nxt      = WRITE;
                end else if (TMO_EN && (tmr_q == TMR_LAST)) begin
                    timeout_err_nxt = 1'b1;
                    rd_req_ack_nxt  = 1'b1;
`ifdef PP_RD_ENC_TAG_EN
                    data_nxt    = '0;
                    to_flag_nxt = 1'b1;
                    state_nxt   = WRITE;
`else
                    state_nxt   = IDLE;
`endif
                end else if (tmr_q != '1) begin
                    tmr_nxt = tmr_q + 1'b1;
                end
            end

            WRITE: begin
                if (!bus.fifo_full) begin
                    fifo_en_nxt   = 1'b1;
`ifdef PP_RD_ENC_TAG_EN
                    fifo_data_nxt = {make_tag(id_q, to_flag_q), data_q};
`else
                    fifo_data_nxt = data_q;
`endif
                    state_nxt     = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State, context and registered outputs; reset discards any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            id_q          <= '0;
            tmr_q         <= '0;
            data_q        <= '0;
`ifdef PP_RD_ENC_TAG_EN
            to_flag_q     <= 1'b0;
`endif
            rd_req_ack_q  <= 1'b0;
            int_ack_q     <= '0;
            fifo_en_q     <= 1'b0;
            fifo_data_q   <= '0;
            timeout_err_q <= 1'b0;
            id_err_q      <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            id_q          <= id_nxt;
            tmr_q         <= tmr_nxt;
            data_q        <= data_nxt;
`ifdef PP_RD_ENC_TAG_EN
            to_flag_q     <= to_flag_nxt;
`endif
            rd_req_ack_q  <= rd_req_ack_nxt;
            int_ack_q     <= int_ack_nxt;
            fifo_en_q     <= fifo_en_nxt;
            fifo_data_q   <= fifo_data_nxt;
            timeout_err_q <= timeout_err_nxt;
            id_err_q      <= id_err_nxt;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.rd_req_ack  = rd_req_ack_q;
    assign bus.int_ack     = int_ack_q;
    assign bus.fifo_en     = fifo_en_q;
    assign bus.fifo_data   = fifo_data_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.id_err      = id_err_q;

endmodule

// File: tb/tb_pp_rd_encoder.sv
// tb_pp_rd_encoder: directed table-driven bench for pp_rd_encoder.
// dut_a: 4 groups, TIMEOUT_CYCLES=8. dut_b: 3 groups, for invalid-ID and busy-ignore cases.
// Honours PP_RD_ENC_TAG_EN for expected FIFO word width/contents.
module tb_pp_rd_encoder;

`ifdef PP_RD_ENC_TAG_EN
    localparam int FW     = 56;
    localparam bit TAGGED = 1'b1;
`else
    localparam int FW     = 48;
    localparam bit TAGGED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pp_rd_encoder_if #(.TOTAL_GRP(4), .ID_W(2), .RD_DATA_BUS_WIDTH(48), .FIFO_W(FW)) ba ();
    pp_rd_encoder_if #(.TOTAL_GRP(3), .ID_W(2), .RD_DATA_BUS_WIDTH(48), .FIFO_W(FW)) bb ();

    pp_rd_encoder #(.TOTAL_GRP(4), .ID_W(2), .RD_DATA_BUS_WIDTH(48), .TIMEOUT_CYCLES(8), .TAG_W(8))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));

    pp_rd_encoder #(.TOTAL_GRP(3), .ID_W(2), .RD_DATA_BUS_WIDTH(48), .TIMEOUT_CYCLES(8), .TAG_W(8))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

    typedef struct {
        logic [1:0]  id;
        int          dly;      // WAIT_DV cycle index where rd_dv is driven; >=8 means never
        logic [47:0] data;
        int          full;     // cycles fifo_full is held high after capture
        logic [3:0]  exp_ack;
        bit          exp_to;
        logic [FW-1:0] exp_word;
    } vec_t;

    vec_t vecs[6];

    // Expected FIFO word: full {tag,data} when tagged, just data otherwise.
    function automatic logic [FW-1:0] mkw(input logic [7:0] tag, input logic [47:0] d);
        return FW'({tag, d});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int i);
        bit done;
        bit wr;
        ba.rd_slave_id = v.id;
        ba.rd_data     = v.data;
        ba.rd_req      = 1'b1;
        tick();                                   // E0: request accepted
        ba.rd_req = 1'b0;
        check($sformatf("v%0d busy_after_req", i), 64'(ba.busy), 64'd1);
        check($sformatf("v%0d int_ack_early", i), 64'(ba.int_ack), 64'd0);
        tick();                                   // E1: acknowledge issued
        check($sformatf("v%0d int_ack", i), 64'(ba.int_ack), 64'(v.exp_ack));
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            ba.rd_dv = (k == v.dly);
            tick();
            ba.rd_dv = 1'b0;
            if (k == 0) check($sformatf("v%0d int_ack_one_cycle", i), 64'(ba.int_ack), 64'd0);
            if (k == v.dly) begin
                check($sformatf("v%0d ack_on_dv", i), 64'(ba.rd_req_ack), 64'd1);
                check($sformatf("v%0d no_timeout", i), 64'(ba.timeout_err), 64'd0);
                done = 1'b1;
            end else if (k == 7) begin
                check($sformatf("v%0d ack_on_timeout", i), 64'(ba.rd_req_ack), 64'd1);
                check($sformatf("v%0d timeout_err", i), 64'(ba.timeout_err), 64'd1);
                done = 1'b1;
            end else begin
                check($sformatf("v%0d ack_wait_k%0d", i, k), 64'(ba.rd_req_ack), 64'd0);
            end
        end
        wr = !v.exp_to || TAGGED;
        ba.fifo_full = (v.full > 0);
        for (int c = 0; c < v.full; c++) begin
            tick();
            check($sformatf("v%0d en_while_full_c%0d", i, c), 64'(ba.fifo_en), 64'd0);
            check($sformatf("v%0d busy_while_full_c%0d", i, c), 64'(ba.busy), 64'(wr));
            if (c == v.full - 1) ba.fifo_full = 1'b0;
        end
        tick();
        check($sformatf("v%0d ack_pulse_end", i), 64'(ba.rd_req_ack), 64'd0);
        check($sformatf("v%0d timeout_pulse_end", i), 64'(ba.timeout_err), 64'd0);
        check($sformatf("v%0d fifo_en", i), 64'(ba.fifo_en), 64'(wr));
        check($sformatf("v%0d fifo_data", i), 64'(ba.fifo_data), wr ? 64'(v.exp_word) : 64'd0);
        check($sformatf("v%0d busy_done", i), 64'(ba.busy), 64'd0);
        tick();
        check($sformatf("v%0d fifo_en_one_cycle", i), 64'(ba.fifo_en), 64'd0);
        check($sformatf("v%0d fifo_data_idle", i), 64'(ba.fifo_data), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt;
        vecs[0] = '{2'd2, 0, 48'hA5A5_0000_1234, 0, 4'b0100, 1'b0, mkw(8'h02, 48'hA5A5_0000_1234)};
        vecs[1] = '{2'd1, 0, 48'h1,              5, 4'b0010, 1'b0, mkw(8'h01, 48'h1)};
        vecs[2] = '{2'd3, 8, 48'hFFFF_FFFF_FFFF, 0, 4'b1000, 1'b1, mkw(8'h83, 48'h0)};
        vecs[3] = '{2'd0, 7, 48'hFF,             0, 4'b0001, 1'b0, mkw(8'h00, 48'hFF)};
        vecs[4] = '{2'd3, 3, 48'hDEAD_BEEF_CAFE, 2, 4'b1000, 1'b0, mkw(8'h03, 48'hDEAD_BEEF_CAFE)};
        vecs[5] = '{2'd2, 8, 48'h1357_9BDF_0246, 3, 4'b0100, 1'b1, mkw(8'h82, 48'h0)};

        ba.rd_req = 1'b0; ba.rd_slave_id = '0; ba.rd_dv = 1'b0; ba.rd_data = '0; ba.fifo_full = 1'b0;
        bb.rd_req = 1'b0; bb.rd_slave_id = '0; bb.rd_dv = 1'b0; bb.rd_data = '0; bb.fifo_full = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst busy_a", 64'(ba.busy), 64'd0);
        check("rst int_ack_a", 64'(ba.int_ack), 64'd0);
        check("rst fifo_en_a", 64'(ba.fifo_en), 64'd0);
        check("rst fifo_data_a", 64'(ba.fifo_data), 64'd0);
        check("rst rd_req_ack_a", 64'(ba.rd_req_ack), 64'd0);
        check("rst flags_a", 64'({ba.timeout_err, ba.id_err}), 64'd0);
        check("rst outs_b", 64'({bb.busy, bb.int_ack, bb.fifo_en, bb.rd_req_ack, bb.timeout_err, bb.id_err}), 64'd0);
        check("rst fifo_data_b", 64'(bb.fifo_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven transactions
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Invalid ID on the 3-group instance
        bb.rd_slave_id = 2'd3;
        bb.rd_req      = 1'b1;
        tick();
        bb.rd_req = 1'b0;
        check("b id_err", 64'(bb.id_err), 64'd1);
        check("b busy_on_bad_id", 64'(bb.busy), 64'd0);
        tick();
        check("b id_err_one_cycle", 64'(bb.id_err), 64'd0);
        check("b int_ack_bad_id", 64'(bb.int_ack), 64'd0);
        check("b busy_after_bad_id", 64'(bb.busy), 64'd0);

        // Valid request, then a second request while busy is ignored
        bb.rd_slave_id = 2'd1;
        bb.rd_req      = 1'b1;
        tick();                                   // E0
        bb.rd_slave_id = 2'd0;                    // still requesting while busy
        check("b busy", 64'(bb.busy), 64'd1);
        tick();                                   // E1
        bb.rd_req = 1'b0;
        check("b int_ack", 64'(bb.int_ack), 64'b010);
        check("b no_id_err_busy", 64'(bb.id_err), 64'd0);
        bb.rd_dv   = 1'b1;
        bb.rd_data = 48'h55;
        tick();                                   // E2
        bb.rd_dv = 1'b0;
        check("b rd_req_ack", 64'(bb.rd_req_ack), 64'd1);
        en_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bb.fifo_en) begin
                en_cnt++;
                check("b fifo_data", 64'(bb.fifo_data), 64'(mkw(8'h01, 48'h55)));
            end
        end
        check("b fifo_writes", 64'(en_cnt), 64'd1);
        check("b int_ack_idle", 64'(bb.int_ack), 64'd0);
        check("b busy_end", 64'(bb.busy), 64'd0);

        // Reset while waiting for data discards the transaction
        ba.rd_slave_id = 2'd1;
        ba.rd_req      = 1'b1;
        tick();
        ba.rd_req = 1'b0;
        tick();
        check("r int_ack_before_rst", 64'(ba.int_ack), 64'b0010);
        rst_n = 1'b0;
        #1;
        check("r int_ack_in_rst", 64'(ba.int_ack), 64'd0);
        check("r busy_in_rst", 64'(ba.busy), 64'd0);
        check("r others_in_rst", 64'({ba.rd_req_ack, ba.fifo_en, ba.timeout_err, ba.id_err}), 64'd0);
        tick();
        rst_n = 1'b1;
        ba.rd_dv   = 1'b1;
        ba.rd_data = 48'h77;
        en_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ba.fifo_en || ba.rd_req_ack || ba.busy) en_cnt++;
        end
        ba.rd_dv = 1'b0;
        check("r no_activity_after_rst", 64'(en_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
